// File: rtl/count_seq_pkg.sv
// Shared types and default parameters for the count sequence checker.
package count_seq_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_ERR_W      = 4;

  // Width of the run counter; LOCK_COUNT is limited to 1..255.
  localparam int unsigned RUN_W = 8;

endpackage

// File: rtl/count_seq_sync.sv
// Two-flop synchronizer with synchronous active-high reset, used for count
// buses that arrive from another board or a pin header.
module count_seq_sync #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a sampled count bus steps by +1 (mod 2^WIDTH) and reports lock,
// error/wrap pulses and a saturating error tally. Define
// COUNT_SEQ_CHECKER_SYNC_EN to put a two-flop synchronizer on the inputs.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_count,
  output logic [1:0]       dbg_state
);

  // Interface: count_vld is a valid-only qualifier with no backpressure; a
  // sample is consumed on every rising edge where count_vld is high, and
  // cycles with count_vld low are ignored entirely.

  localparam logic [RUN_W:0]   LOCK_TGT = (RUN_W + 1)'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [WIDTH-1:0] smp_cnt;
  logic             smp_vld;

`ifdef COUNT_SEQ_CHECKER_SYNC_EN
  logic [WIDTH:0] sync_out;

  count_seq_sync #(
    .W (WIDTH + 1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({count_vld, count_in}),
    .q_o (sync_out)
  );

  assign smp_vld = sync_out[WIDTH];
  assign smp_cnt = sync_out[WIDTH-1:0];
`else
  assign smp_vld = count_vld;
  assign smp_cnt = count_in;
`endif

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [ERR_W-1:0] errc_q, errc_d;
  logic             locked_q, locked_d;
  logic             errp_q, errp_d;
  logic             wrapp_q, wrapp_d;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic [RUN_W:0]   run_inc;

  assign expected = last_q + WIDTH'(1);
  assign match    = (smp_cnt == expected);
  assign run_inc  = {1'b0, run_q} + (RUN_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    errc_d  = errc_q;
    errp_d  = 1'b0;
    wrapp_d = 1'b0;

    if (smp_vld) begin
      last_d = smp_cnt;
      case (state_q)
        UNLOCKED: begin
          run_d   = '0;
          state_d = LOCKING;
        end
        LOCKING: begin
          if (match) begin
            run_d = run_inc[RUN_W-1:0];
            if (run_inc == LOCK_TGT) begin
              state_d = LOCKED;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrapp_d = (smp_cnt == '0);
          end else begin
            // Drop back to LOCKING reseeded on the offending sample.
            errp_d  = 1'b1;
            run_d   = '0;
            state_d = LOCKING;
            if (errc_q != ERR_MAX) begin
              errc_d = errc_q + ERR_W'(1);
            end
          end
        end
        default: begin
          run_d   = '0;
          state_d = UNLOCKED;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      run_q    <= '0;
      last_q   <= '0;
      errc_q   <= '0;
      locked_q <= 1'b0;
      errp_q   <= 1'b0;
      wrapp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      last_q   <= last_d;
      errc_q   <= errc_d;
      locked_q <= locked_d;
      errp_q   <= errp_d;
      wrapp_q  <= wrapp_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = errp_q;
  assign wrap_pulse = wrapp_q;
  assign err_count  = errc_q;
  assign last_count = last_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receiving end of the free-running counter bus: samples an N-bit count stream, e.g. counter8bits output routed between iCE40-HX8K tiles or pins.
- Checks that each sample equals the previous sample +1, modulo 2^WIDTH.
- Reports lock status, error pulses, wrap pulses and a saturating error tally that can drive board LEDs.
- Sits downstream of the counter in the same clock domain, or behind the optional synchronizer.

Parameters:
- WIDTH, 8: count bus width in bits.
- LOCK_COUNT, 4: consecutive correct increments needed to declare lock; range 1..255.
- ERR_W, 4: error tally width; the tally saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  observed count bus.
- count_vld  input  1  sample qualifier; tie high when the counter steps every clk.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse on a mismatch detected in LOCKED.
- wrap_pulse  output  1  one-cycle pulse when a correct 2^WIDTH-1 -> 0 step occurs in LOCKED.
- err_count  output  ERR_W  saturating mismatch tally.
- last_count  output  WIDTH  most recent accepted sample.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs go to 0: locked, err_pulse, wrap_pulse, err_count, last_count.
  - State goes to UNLOCKED; run counter goes to 0.
  - Reset overrides all other inputs in the same cycle.
- Sampling: only cycles with count_vld=1 are evaluated. With count_vld=0, state, run, last_count and err_count hold, and both pulses are 0.
- expected = last_count + 1, truncated to WIDTH bits, so wrap is natural.
- State UNLOCKED, on a vld sample:
  - last_count <= count_in; run <= 0; go to LOCKING.
  - No error is raised.
- State LOCKING, on a vld sample:
  - Match: run <= run+1. If run+1 == LOCK_COUNT, go to LOCKED.
  - Mismatch: reseed last_count <= count_in, run <= 0, stay in LOCKING. No err_pulse, and err_count is unchanged.
- State LOCKED, on a vld sample:
  - Match: stay in LOCKED. If count_in == 0, set wrap_pulse.
  - Mismatch: err_pulse=1; err_count <= err_count+1 unless already all-ones; last_count <= count_in; run <= 0; go to LOCKING.
- last_count updates on every vld sample, in every state.
- Latency: all outputs are registered.
  - locked, err_pulse and wrap_pulse assert on the clk edge that samples the deciding count_in, so they are visible the cycle after that sample is presented.
  - locked drops on the same edge that raises err_pulse.
- Boundary cases:
  - LOCK_COUNT=1: lock on the first matching sample after the seed.
  - A count frozen with vld=1 is a mismatch (x -> x).
  - A backwards or jumping value is a mismatch.
  - err_count never wraps.

Optional Feature:
- Macro: COUNT_SEQ_CHECKER_SYNC_EN.
- When defined: count_in and count_vld pass through a two-stage flip-flop synchronizer before the checker, for buses arriving from another board or pin header.
  - Adds 2 cycles to every latency above.
  - Synchronizer flops reset to 0 with rst.
- When undefined: inputs feed the checker directly, with zero added latency.

Decomposition:
- Package count_seq_pkg holds:
  - State encoding constants: UNLOCKED=2'd0, LOCKING=2'd1, LOCKED=2'd2.
  - Default parameter constants.
- Sub-module count_seq_sync: parameterized WIDTH+1 bit, two-flop synchronizer with synchronous reset. Instantiated only under COUNT_SEQ_CHECKER_SYNC_EN.

Test Plan:
Conditions: WIDTH=8, LOCK_COUNT=4, ERR_W=4, vld=1 unless stated.
1. Lock: reset, then feed 0,1,2,3,4 on consecutive cycles -> locked=1 the cycle after sample 4; err_count=0; last_count=4.
2. Wrap: locked, feed 253,254,255,0,1 -> single wrap_pulse the cycle after sample 0; err_pulse never asserts; locked stays 1.
3. Glitch: locked at 10, feed 11,13,14,15,16,17 ->
   - err_pulse for one cycle and locked=0 after sample 13; err_count=1.
   - locked=1 again after sample 17.
4. Hold: locked at 50, vld=0 for 6 cycles while count_in toggles between 0xAA and 0x00, then vld=1 with 51 -> no pulses; locked stays 1; last_count=51.
5. Saturation: repeat lock-then-glitch 20 times -> err_count reaches 15 and stays 15.
6. Reset mid-operation: locked with err_count=3, assert rst for 1 cycle -> next cycle all outputs 0; feeding 7,8,9,10,11 relocks after 11.
